// File: rtl/axi_nibble_master_if.sv
// Bus bundle for the 4-bit-address / 4-bit-data AXI-lite-style nibble link.
// The master modport drives the ms_* signals; the slave modport drives the sm_* signals.
interface axi_nibble_master_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
);
  logic              ms_arvalid;
  logic [ADDR_W-1:0] ms_araddr;
  logic              sm_arready;
  logic              sm_rvalid;
  logic [DATA_W-1:0] sm_rdata;
  logic              ms_rready;
  logic              ms_awvalid;
  logic [ADDR_W-1:0] ms_awaddr;
  logic              sm_awready;
  logic              ms_wvalid;
  logic [DATA_W-1:0] ms_wdata;
  logic              sm_wready;

  modport master (
    output ms_arvalid, ms_araddr, ms_rready,
    output ms_awvalid, ms_awaddr, ms_wvalid, ms_wdata,
    input  sm_arready, sm_rvalid, sm_rdata, sm_awready, sm_wready
  );

  modport slave (
    input  ms_arvalid, ms_araddr, ms_rready,
    input  ms_awvalid, ms_awaddr, ms_wvalid, ms_wdata,
    output sm_arready, sm_rvalid, sm_rdata, sm_awready, sm_wready
  );
endinterface

// File: rtl/axi_nibble_master.sv
// Initiator end of the nibble AXI-lite-style link: takes one read or write
// command at a time, runs the AR/R or AW/W handshakes and returns a one-cycle
// response strobe. All outputs come straight from flops.
// Optional watchdog: define TIMEOUT_EN to abort a transaction that has been
// busy for TIMEOUT_CYCLES cycles; without it the master waits indefinitely and
// resp_timeout is tied low.
module axi_nibble_master #(
  parameter int ADDR_W         = 4,
  parameter int DATA_W         = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_timeout,
  axi_nibble_master_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR,
    RESP
  } state_e;

  state_e            state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              arvalid_q, arvalid_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic              rready_q, rready_d;
  logic              awvalid_q, awvalid_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic              wvalid_q, wvalid_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              aw_fin;
  logic              w_fin;

`ifdef TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              resp_timeout_q, resp_timeout_d;
  assign resp_timeout = resp_timeout_q;
`else
  assign resp_timeout = 1'b0;
`endif

  assign cmd_ready      = cmd_ready_q;
  assign resp_valid     = resp_valid_q;
  assign resp_rdata     = resp_rdata_q;
  assign bus.ms_arvalid = arvalid_q;
  assign bus.ms_araddr  = araddr_q;
  assign bus.ms_rready  = rready_q;
  assign bus.ms_awvalid = awvalid_q;
  assign bus.ms_awaddr  = awaddr_q;
  assign bus.ms_wvalid  = wvalid_q;
  assign bus.ms_wdata   = wdata_q;

  // A write channel counts as finished if it completed earlier or handshakes now.
  assign aw_fin = aw_done_q | (awvalid_q & bus.sm_awready);
  assign w_fin  = w_done_q  | (wvalid_q  & bus.sm_wready);

  // Next-state and next-output logic; every output is computed here and registered below.
  always_comb begin
    state_d      = state_q;
    cmd_ready_d  = cmd_ready_q;
    arvalid_d    = arvalid_q;
    araddr_d     = araddr_q;
    rready_d     = rready_q;
    awvalid_d    = awvalid_q;
    awaddr_d     = awaddr_q;
    wvalid_d     = wvalid_q;
    wdata_d      = wdata_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
`ifdef TIMEOUT_EN
    cnt_d          = cnt_q;
    resp_timeout_d = resp_timeout_q;
`endif

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cmd_ready_d  = 1'b0;
          resp_rdata_d = '0;
`ifdef TIMEOUT_EN
          cnt_d          = '0;
          resp_timeout_d = 1'b0;
`endif
          if (cmd_write) begin
            state_d   = WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = RD_ADDR;
            arvalid_d = 1'b1;
            araddr_d  = cmd_addr;
          end
        end
      end
      RD_ADDR: begin
        if (arvalid_q && bus.sm_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (rready_q && bus.sm_rvalid) begin
          rready_d     = 1'b0;
          resp_rdata_d = bus.sm_rdata;
          state_d      = RESP;
        end
      end
      WR: begin
        if (awvalid_q && bus.sm_awready) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (wvalid_q && bus.sm_wready) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_fin && w_fin) begin
          state_d = RESP;
        end
      end
      RESP: begin
        resp_valid_d = 1'b1;
        cmd_ready_d  = 1'b1;
        state_d      = IDLE;
`ifdef TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      default: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
      end
    endcase

`ifdef TIMEOUT_EN
    if (state_q == RD_ADDR || state_q == RD_DATA || state_q == WR) begin
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        arvalid_d      = 1'b0;
        rready_d       = 1'b0;
        awvalid_d      = 1'b0;
        wvalid_d       = 1'b0;
        resp_rdata_d   = '0;
        resp_timeout_d = 1'b1;
        state_d        = RESP;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif
  end

  // State and output flops; reset drops every valid/ready at once and returns to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cmd_ready_q  <= 1'b1;
      arvalid_q    <= 1'b0;
      araddr_q     <= '0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      awaddr_q     <= '0;
      wvalid_q     <= 1'b0;
      wdata_q      <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
`ifdef TIMEOUT_EN
      cnt_q          <= '0;
      resp_timeout_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      arvalid_q    <= arvalid_d;
      araddr_q     <= araddr_d;
      rready_q     <= rready_d;
      awvalid_q    <= awvalid_d;
      awaddr_q     <= awaddr_d;
      wvalid_q     <= wvalid_d;
      wdata_q      <= wdata_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
`ifdef TIMEOUT_EN
      cnt_q          <= cnt_d;
      resp_timeout_q <= resp_timeout_d;
`endif
    end
  end

endmodule

// File: tb/tb_axi_nibble_master.sv
// Self-checking bench for axi_nibble_master: directed scenarios with literal
// expectations, then randomized command and subordinate traffic compared every
// cycle against a channel-level behavioural model. Define TIMEOUT_EN to also
// exercise the watchdog.
module tb_axi_nibble_master;

  localparam int AW   = 4;
  localparam int DW   = 4;
  localparam int TOUT = 15;
`ifdef TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_timeout;

  int total = 0;
  int bad   = 0;

  axi_nibble_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  axi_nibble_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_timeout (resp_timeout),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  // Model state: which channel handshakes are still owed, the latched command,
  // and where the response sits (one cycle of wait, then the strobe cycle).
  logic          m_busy, m_ar, m_r, m_aw, m_w;
  logic          m_resp_wait, m_resp_now, m_tout;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  int            m_elapsed;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model updated once per clock from the sampled inputs.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_ar <= 1'b0; m_r <= 1'b0; m_aw <= 1'b0; m_w <= 1'b0;
      m_resp_wait <= 1'b0; m_resp_now <= 1'b0; m_tout <= 1'b0;
      m_addr <= '0; m_wdata <= '0; m_rdata <= '0; m_elapsed <= 0;
    end else begin
      m_resp_now  <= m_resp_wait;
      m_resp_wait <= 1'b0;
      if (m_resp_wait) m_busy <= 1'b0;
      if (!m_busy && cmd_valid) begin
        m_busy    <= 1'b1;
        m_addr    <= cmd_addr;
        m_wdata   <= cmd_wdata;
        m_rdata   <= '0;
        m_tout    <= 1'b0;
        m_elapsed <= 0;
        m_ar      <= !cmd_write;
        m_aw      <= cmd_write;
        m_w       <= cmd_write;
      end else if (m_ar || m_r || m_aw || m_w) begin
        if (TIMEOUT_ON && (m_elapsed + 1 == TOUT)) begin
          m_ar <= 1'b0; m_r <= 1'b0; m_aw <= 1'b0; m_w <= 1'b0;
          m_resp_wait <= 1'b1;
          m_tout      <= 1'b1;
          m_rdata     <= '0;
        end else begin
          m_elapsed <= m_elapsed + 1;
          if (m_ar && bus.sm_arready) begin
            m_ar <= 1'b0;
            m_r  <= 1'b1;
          end
          if (m_r && bus.sm_rvalid) begin
            m_r         <= 1'b0;
            m_rdata     <= bus.sm_rdata;
            m_resp_wait <= 1'b1;
          end
          if (m_aw && bus.sm_awready) m_aw <= 1'b0;
          if (m_w && bus.sm_wready) m_w <= 1'b0;
          if ((m_aw || m_w) && (!m_aw || bus.sm_awready) && (!m_w || bus.sm_wready))
            m_resp_wait <= 1'b1;
        end
      end
    end
  end

  // Compare every DUT output against the model on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("cmd_ready", cmd_ready, !m_busy);
      checkOutput("arvalid", bus.ms_arvalid, m_ar);
      checkOutput("rready", bus.ms_rready, m_r);
      checkOutput("awvalid", bus.ms_awvalid, m_aw);
      checkOutput("wvalid", bus.ms_wvalid, m_w);
      checkOutput("resp_valid", resp_valid, m_resp_now);
      if (m_ar) checkOutput("araddr", bus.ms_araddr, m_addr);
      if (m_aw) checkOutput("awaddr", bus.ms_awaddr, m_addr);
      if (m_w) checkOutput("wdata", bus.ms_wdata, m_wdata);
      if (m_resp_now) begin
        checkOutput("resp_rdata", resp_rdata, m_rdata);
        checkOutput("resp_timeout", resp_timeout, m_tout);
      end
    end
  end

  // Present a command and wait until it is accepted; t_acc is the accept cycle's falling edge.
  task automatic applyStimulus(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                               output time t_acc);
    @(posedge clk);
    #1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    t_acc     = $time;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) begin
        t_acc = $time;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        return;
      end
    end
    total++;
    bad++;
    $display("[TB] FAIL accept: cmd_ready never seen within 40 cycles");
    cmd_valid = 1'b0;
  endtask

  // Wait for the response strobe; latency is counted in cycles from the accept cycle.
  task automatic waitResp(input time t_acc, output int lat);
    lat = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        lat = int'(($time - t_acc) / 10);
        return;
      end
    end
    total++;
    bad++;
    $display("[TB] FAIL resp_wait: no resp_valid within 60 cycles");
  endtask

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    time tA;
    int  lat;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    bus.sm_arready = 1'b0; bus.sm_rvalid = 1'b0; bus.sm_rdata = '0;
    bus.sm_awready = 1'b0; bus.sm_wready = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("reset cmd_ready", cmd_ready, 1);
    checkOutput("reset arvalid", bus.ms_arvalid, 0);
    checkOutput("reset rready", bus.ms_rready, 0);
    checkOutput("reset awvalid", bus.ms_awvalid, 0);
    checkOutput("reset wvalid", bus.ms_wvalid, 0);
    checkOutput("reset araddr", bus.ms_araddr, 0);
    checkOutput("reset awaddr", bus.ms_awaddr, 0);
    checkOutput("reset wdata", bus.ms_wdata, 0);
    checkOutput("reset resp_valid", resp_valid, 0);
    checkOutput("reset resp_rdata", resp_rdata, 0);
    checkOutput("reset resp_timeout", resp_timeout, 0);
    #2 rst = 1'b0;

    $display("[TB] zero-wait read");
    bus.sm_arready = 1'b1; bus.sm_rvalid = 1'b1; bus.sm_rdata = 4'h5;
    applyStimulus(1'b0, 4'hA, 4'h0, tA);
    @(negedge clk);
    checkOutput("t1 arvalid", bus.ms_arvalid, 1);
    checkOutput("t1 araddr", bus.ms_araddr, 4'hA);
    waitResp(tA, lat);
    checkOutput("t1 latency", lat, 4);
    checkOutput("t1 rdata", resp_rdata, 4'h5);
    bus.sm_arready = 1'b0; bus.sm_rvalid = 1'b0;

    $display("[TB] read with waits");
    applyStimulus(1'b0, 4'h6, 4'h0, tA);
    repeat (3) @(posedge clk);
    #1 bus.sm_arready = 1'b1;
    @(posedge clk);
    #1 bus.sm_arready = 1'b0;
    repeat (2) @(posedge clk);
    #1 bus.sm_rvalid = 1'b1; bus.sm_rdata = 4'h9;
    waitResp(tA, lat);
    checkOutput("t2 latency", lat, 9);
    checkOutput("t2 rdata", resp_rdata, 4'h9);
    bus.sm_rvalid = 1'b0;

    $display("[TB] skewed write");
    bus.sm_wready = 1'b1;
    applyStimulus(1'b1, 4'h3, 4'hC, tA);
    @(posedge clk);
    #1 bus.sm_wready = 1'b0;
    @(negedge clk);
    checkOutput("t3 wvalid", bus.ms_wvalid, 0);
    checkOutput("t3 awvalid", bus.ms_awvalid, 1);
    checkOutput("t3 awaddr", bus.ms_awaddr, 4'h3);
    @(posedge clk);
    #1 bus.sm_awready = 1'b1;
    @(posedge clk);
    #1 bus.sm_awready = 1'b0;
    waitResp(tA, lat);
    checkOutput("t3 latency", lat, 5);
    checkOutput("t3 rdata", resp_rdata, 0);

    $display("[TB] simultaneous write");
    bus.sm_awready = 1'b1; bus.sm_wready = 1'b1;
    applyStimulus(1'b1, 4'h8, 4'h1, tA);
    @(negedge clk);
    checkOutput("t4 awvalid on", bus.ms_awvalid, 1);
    checkOutput("t4 wvalid on", bus.ms_wvalid, 1);
    checkOutput("t4 wdata", bus.ms_wdata, 4'h1);
    @(negedge clk);
    checkOutput("t4 awvalid off", bus.ms_awvalid, 0);
    checkOutput("t4 wvalid off", bus.ms_wvalid, 0);
    waitResp(tA, lat);
    checkOutput("t4 latency", lat, 3);
    checkOutput("t4 rdata", resp_rdata, 0);
    bus.sm_awready = 1'b0; bus.sm_wready = 1'b0;

    $display("[TB] reset during read");
    applyStimulus(1'b0, 4'hF, 4'h0, tA);
    @(negedge clk);
    checkOutput("t5 arvalid before", bus.ms_arvalid, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("t5 arvalid async", bus.ms_arvalid, 0);
    checkOutput("t5 cmd_ready async", cmd_ready, 1);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("t5 no resp", resp_valid, 0);
      checkOutput("t5 idle", cmd_ready, 1);
    end

`ifdef TIMEOUT_EN
    $display("[TB] watchdog abort");
    applyStimulus(1'b0, 4'h2, 4'h0, tA);
    waitResp(tA, lat);
    checkOutput("t6 latency", lat, 17);
    checkOutput("t6 timeout", resp_timeout, 1);
    checkOutput("t6 rdata", resp_rdata, 0);
    bus.sm_arready = 1'b1; bus.sm_rvalid = 1'b1; bus.sm_rdata = 4'h7;
    applyStimulus(1'b0, 4'h4, 4'h0, tA);
    waitResp(tA, lat);
    checkOutput("t6 next latency", lat, 4);
    checkOutput("t6 next timeout", resp_timeout, 0);
    checkOutput("t6 next rdata", resp_rdata, 4'h7);
    bus.sm_arready = 1'b0; bus.sm_rvalid = 1'b0;
`endif

    $display("[TB] random traffic");
    for (int c = 0; c < 4000; c++) begin
      bit quiet;
      quiet = ((c / 40) % 10) == 9;
      @(posedge clk);
      #1;
      cmd_valid      = ($urandom_range(0, 2) != 0);
      cmd_write      = 1'($urandom_range(0, 1));
      cmd_addr       = 4'($urandom);
      cmd_wdata      = 4'($urandom);
      bus.sm_arready = !quiet && ($urandom_range(0, 2) != 0);
      bus.sm_rvalid  = !quiet && ($urandom_range(0, 2) != 0);
      bus.sm_rdata   = 4'($urandom);
      bus.sm_awready = !quiet && ($urandom_range(0, 2) != 0);
      bus.sm_wready  = !quiet && ($urandom_range(0, 2) != 0);
    end
    cmd_valid = 1'b0;
    bus.sm_arready = 1'b1; bus.sm_rvalid = 1'b1; bus.sm_awready = 1'b1; bus.sm_wready = 1'b1;
    repeat (40) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
